// File: rtl/alu_regfile_pipe.sv
// Registered ALU with an iterative multiplier and a result register file.
// Single-cycle ops pass through one capture stage and complete one edge
// after acceptance; MUL holds the block busy while a shift-add loop runs.
//
// state | meaning
// IDLE  | ready for a new op; single-cycle ops flow through the capture stage
// MUL   | shift-add multiply in progress, one multiplier bit per cycle
module alu_regfile_pipe #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [2:0]        sel,
    input  logic [ADDR_W-1:0] wr_addr,
    output logic [WIDTH:0]    c,
    output logic              out_valid,
    output logic              zero,
    output logic              ovf,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH:0]    d_out
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CW    = $clog2(WIDTH + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] MUL  = 1'b1;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_NOT = 3'd5;
    localparam logic [2:0] OP_SHL = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    logic [0:0]          state;
    logic                accept;

    // capture stage for single-cycle ops
    logic                p_valid;
    logic [WIDTH-1:0]    p_a;
    logic [WIDTH-1:0]    p_b;
    logic [2:0]          p_sel;
    logic [ADDR_W-1:0]   p_addr;

    // multiplier datapath
    logic [2*WIDTH-1:0]  m_acc;
    logic [2*WIDTH-1:0]  m_cand;
    logic [WIDTH-1:0]    m_plier;
    logic [CW-1:0]       m_cnt;
    logic [2*WIDTH-1:0]  m_sum;
    logic                m_last;

    logic [WIDTH:0]      alu_res;
    logic                alu_ovf;
    logic                res_valid;
    logic [WIDTH:0]      res;
    logic                res_ovf;

    logic [WIDTH:0]      mem [DEPTH];

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;

    // single-cycle ALU on the captured operands
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (p_sel)
            OP_ADD: begin
                alu_res = {1'b0, p_a} + {1'b0, p_b};
                alu_ovf = alu_res[WIDTH];
            end
            OP_SUB: begin
                alu_res = {1'b0, p_a} - {1'b0, p_b};
                alu_ovf = (p_a < p_b);
            end
            OP_AND:  alu_res = {1'b0, p_a & p_b};
            OP_OR:   alu_res = {1'b0, p_a | p_b};
            OP_XOR:  alu_res = {1'b0, p_a ^ p_b};
            OP_NOT:  alu_res = {1'b0, ~p_a};
            OP_SHL:  alu_res = {p_a, 1'b0};
            default: alu_res = '0;
        endcase
    end

    // next partial product and completion select; the final iteration's sum
    // feeds the result directly so MUL completes on its last loop edge
    always_comb begin
        m_sum     = m_acc + (m_plier[0] ? m_cand : '0);
        m_last    = (state == MUL) && (m_cnt == '0);
        res_valid = p_valid || m_last;
        res       = p_valid ? alu_res : m_sum[WIDTH:0];
        res_ovf   = p_valid ? alu_ovf : (|m_sum[2*WIDTH-1:WIDTH+1]);
    end

    // FSM and operand capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            p_valid <= 1'b0;
            p_a     <= '0;
            p_b     <= '0;
            p_sel   <= '0;
            p_addr  <= '0;
        end else begin
            p_valid <= accept && (sel != OP_MUL);
            if (accept) begin
                p_a    <= a;
                p_b    <= b;
                p_sel  <= sel;
                p_addr <= wr_addr;
                if (sel == OP_MUL) state <= MUL;
            end else if (m_last) begin
                state <= IDLE;
            end
        end
    end

    // shift-add multiplier: load on accept, iterate while in MUL
    always_ff @(posedge clk) begin
        if (rst) begin
            m_acc   <= '0;
            m_cand  <= '0;
            m_plier <= '0;
            m_cnt   <= '0;
        end else if (accept && (sel == OP_MUL)) begin
            m_acc   <= '0;
            m_cand  <= {{WIDTH{1'b0}}, a};
            m_plier <= b;
            m_cnt   <= CW'(WIDTH - 1);
        end else if (state == MUL) begin
            m_acc   <= m_sum;
            m_cand  <= m_cand << 1;
            m_plier <= m_plier >> 1;
            m_cnt   <= m_cnt - CW'(1);
        end
    end

    // result and flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            c         <= '0;
            out_valid <= 1'b0;
            zero      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            out_valid <= res_valid;
            if (res_valid) begin
                c    <= res;
                zero <= (res == '0);
                ovf  <= res_ovf;
            end
        end
    end

    // register file write and read-first registered read
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            d_out <= '0;
        end else begin
            if (res_valid) mem[p_addr] <= res;
            d_out <= mem[rd_addr];
        end
    end

endmodule

// File: tb/tb_alu_regfile_pipe.sv
// Directed bench for alu_regfile_pipe: expected results are queued at issue
// and checked against each out_valid pulse; a shadow of the register file
// checks the read port.
module tb_alu_regfile_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] sel;
    logic [3:0] wr_addr;
    logic [8:0] c;
    logic       out_valid;
    logic       zero;
    logic       ovf;
    logic [3:0] rd_addr;
    logic [8:0] d_out;

    alu_regfile_pipe #(.WIDTH(8), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sel(sel), .wr_addr(wr_addr), .c(c),
        .out_valid(out_valid), .zero(zero), .ovf(ovf),
        .rd_addr(rd_addr), .d_out(d_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] c;
        logic       z;
        logic       o;
        logic [3:0] addr;
    } exp_t;

    exp_t       sb[$];
    logic [8:0] shadow [16];
    int         vectors = 0;
    int         miscompares = 0;
    int         done_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] s, input logic [7:0] x,
                                   input logic [7:0] y, input logic [3:0] ad);
        exp_t e;
        int   ix = x;
        int   iy = y;
        int   r = 0;
        bit   o = 0;
        case (s)
            3'd0: begin r = ix + iy; o = (r > 255); end
            3'd1: begin r = (ix - iy) & 511; o = (ix < iy); end
            3'd2: r = ix & iy;
            3'd3: r = ix | iy;
            3'd4: r = ix ^ iy;
            3'd5: r = (~ix) & 255;
            3'd6: r = (ix << 1) & 511;
            default: begin r = ix * iy; o = (r > 511); r = r & 511; end
        endcase
        e.c    = r[8:0];
        e.z    = (r[8:0] == 9'd0);
        e.o    = o;
        e.addr = ad;
        return e;
    endfunction

    // one clock edge; outputs sampled 1 time unit later
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (out_valid === 1'b1) begin
            done_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_out_valid", 32'(out_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                check("c", 32'(c), 32'(e.c));
                check("zero", 32'(zero), 32'(e.z));
                check("ovf", 32'(ovf), 32'(e.o));
                shadow[e.addr] = e.c;
            end
        end
    endtask

    // drive one op across one edge; expect_acc states whether in_ready should be high
    task automatic issue(input logic [2:0] s, input logic [7:0] x, input logic [7:0] y,
                         input logic [3:0] ad, input bit expect_acc);
        in_valid = 1'b1;
        sel      = s;
        a        = x;
        b        = y;
        wr_addr  = ad;
        check("in_ready_at_issue", 32'(in_ready), 32'(expect_acc));
        if (expect_acc) sb.push_back(model(s, x, y, ad));
        tick();
    endtask

    task automatic read_check(input logic [3:0] ad, input string tag);
        rd_addr = ad;
        tick();
        check(tag, 32'(d_out), 32'(shadow[ad]));
    endtask

    // waits for the next completion while holding in_valid high with junk;
    // returns the number of edges taken, or 0 if the budget expired
    task automatic wait_done(input int budget, output int lat);
        int start = done_cnt;
        lat = 0;
        in_valid = 1'b1;
        sel = 3'd0; a = 8'hAA; b = 8'h55; wr_addr = 4'hF;
        for (int i = 1; i <= budget; i++) begin
            check("in_ready_busy", 32'(in_ready), 32'd0);
            tick();
            if (done_cnt != start) begin
                lat = i;
                break;
            end
        end
        in_valid = 1'b0;
        if (lat == 0) check("mul_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int lat;
        int start;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sel = '0; wr_addr = '0; rd_addr = '0;
        for (int i = 0; i < 16; i++) shadow[i] = '0;

        tick(); tick();
        rst = 1'b0;
        check("rst_c", 32'(c), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_zero_ovf", {zero, ovf}, 32'd0);
        for (int i = 0; i < 16; i++) read_check(4'(i), "rst_mem");

        // back-to-back single-cycle ops
        start = done_cnt;
        issue(3'd0, 8'h05, 8'h88, 4'd0, 1);
        issue(3'd1, 8'h05, 8'h88, 4'd1, 1);
        issue(3'd2, 8'h05, 8'h88, 4'd2, 1);
        issue(3'd3, 8'h05, 8'h88, 4'd3, 1);
        in_valid = 1'b0;
        tick();
        check("b2b_completions", 32'(done_cnt - start), 32'd4);
        tick();
        check("b2b_idle_after", 32'(out_valid), 32'd0);
        for (int i = 0; i < 4; i++) read_check(4'(i), "b2b_mem");

        // remaining single-cycle opcodes
        issue(3'd4, 8'hF0, 8'h3C, 4'd10, 1);
        issue(3'd5, 8'h5A, 8'h00, 4'd11, 1);
        issue(3'd6, 8'hC3, 8'h00, 4'd12, 1);
        in_valid = 1'b0;
        tick(); tick();
        for (int i = 10; i < 13; i++) read_check(4'(i), "misc_mem");

        // MUL 12*13 with ignored requests while busy
        issue(3'd7, 8'd12, 8'd13, 4'd5, 1);
        wait_done(20, lat);
        check("mul_latency", 32'(lat), 32'd8);
        check("mul_ready_back", 32'(in_ready), 32'd1);
        tick();
        check("mul_single_pulse", 32'(out_valid), 32'd0);
        read_check(4'd5, "mul_mem5");
        read_check(4'd15, "busy_junk_not_written");

        // MUL with high product bits, then ADD with carry
        issue(3'd7, 8'h05, 8'h88, 4'd6, 1);
        wait_done(20, lat);
        check("mul2_latency", 32'(lat), 32'd8);
        issue(3'd0, 8'hFF, 8'hFF, 4'd8, 1);
        in_valid = 1'b0;
        tick();
        read_check(4'd6, "mul2_mem");
        read_check(4'd8, "add_ff_mem");

        // reset in the middle of a MUL
        issue(3'd7, 8'd3, 8'd3, 4'd9, 1);
        in_valid = 1'b0;
        tick(); tick();
        rst = 1'b1;
        sb.delete();
        for (int i = 0; i < 16; i++) shadow[i] = '0;
        tick();
        rst = 1'b0;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        start = done_cnt;
        for (int i = 0; i < 10; i++) tick();
        check("abort_no_completion", 32'(done_cnt - start), 32'd0);
        for (int i = 0; i < 16; i++) read_check(4'(i), "abort_mem");

        // read-first collision on address 7
        shadow[7] = '0;
        rd_addr = 4'd7;
        issue(3'd0, 8'd1, 8'd2, 4'd7, 1);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("collision_out_valid", 32'(out_valid), 32'd1);
        check("collision_old", 32'(d_out), 32'd0);
        if (out_valid === 1'b1 && sb.size() != 0) void'(sb.pop_front());
        tick();
        check("collision_new", 32'(d_out), 32'd3);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_regfile_pipe.md
Name: alu_regfile_pipe

Overview:
Parametrised registered ALU with an on-chip result register file. Each accepted operation produces a registered (WIDTH+1)-bit result with status flags. The result is written into a DEPTH-entry register file at a caller-supplied address. An independent read port returns stored results. Adds three things over the fixed 8-bit ALU: a valid/ready handshake, an iterative multi-cycle multiply, and zero/overflow flags.

Parameters:
WIDTH, 8, operand width; results are WIDTH+1 bits.
ADDR_W, 4, register-file address width; DEPTH = 2**ADDR_W entries.

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  operation request
in_ready  output  1  block can accept an operation this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
sel  input  3  opcode
wr_addr  input  ADDR_W  register-file entry written with this op's result
c  output  WIDTH+1  registered result of last completed op
out_valid  output  1  one-cycle pulse, c/flags updated
zero  output  1  c == 0 for last completed op
ovf  output  1  overflow/borrow flag for last completed op
rd_addr  input  ADDR_W  read address
d_out  output  WIDTH+1  registered register-file read data

Behaviour:
- Reset (rst=1 at an edge): c=0, out_valid=0, zero=0, ovf=0, d_out=0, in_ready=1, FSM to IDLE, all DEPTH entries cleared to 0. Reset overrides everything, including an in-flight MUL, which is aborted with no write.
- Accept: the operation is accepted when in_valid && in_ready at a rising edge. a, b, sel and wr_addr are captured at that edge. When in_ready=0, in_valid is ignored; no queueing.
- Opcodes (results zero-extended to WIDTH+1 unless stated):
  - 0 ADD: {carry, a+b}; ovf = carry.
  - 1 SUB: (a-b) mod 2^(WIDTH+1); ovf = borrow (a<b).
  - 2 AND: ovf=0.
  - 3 OR: ovf=0.
  - 4 XOR: ovf=0.
  - 5 NOT a: ovf=0.
  - 6 SHL1: {a, 1'b0} (bit WIDTH = a[WIDTH-1]); ovf=0.
  - 7 MUL: unsigned a*b, low WIDTH+1 bits; ovf=1 iff any higher product bit is nonzero.
- zero = (c == 0), computed on the (WIDTH+1)-bit result.
- FSM states:
  - IDLE: in_ready=1. Accepting ops 0-6 stays in IDLE. Accepting op 7 goes to MUL.
  - MUL: in_ready=0. Iterative shift-add, one multiplier bit per cycle, WIDTH iterations. After the last iteration, return to IDLE.
- Single-cycle op latency: accepted at edge N. c, flags and register-file entry wr_addr all update at edge N+1. out_valid=1 for the cycle after edge N+1. Back-to-back accepts every cycle are supported.
- MUL latency: accepted at edge N. in_ready=0 from after edge N until after edge N+WIDTH. At edge N+WIDTH, c, flags and the register-file write update and out_valid pulses. in_ready returns to 1 in the same cycle that out_valid is 1.
- out_valid is 0 in every cycle without a completion.
- Register-file write happens at the same edge c updates, exactly once per completed op.
- Read port: d_out <= mem[rd_addr] every edge, one-cycle latency, read-first. If the same address is written at the same edge, d_out shows the old value; the new value appears one edge later.
- Address wrap: addresses are ADDR_W bits; there is no out-of-range case.

Test Plan:
- WIDTH=8, after reset: read all 16 entries -> d_out=0; c=0, out_valid=0, in_ready=1.
- a=0x05, b=0x88, back-to-back ops 0,1,2,3 to addr 0-3 -> c = 0x08D (ovf0), 0x17D (ovf1), 0x000 (zero1), 0x08D. out_valid high on 4 consecutive cycles. Reading addr 0-3 returns the same values.
- MUL a=12, b=13, addr 5 -> in_ready low for 8 cycles. in_valid pulses during busy are ignored. c=0x09C, ovf=0, out_valid exactly 8 edges after accept. mem[5]=0x09C.
- MUL a=0x05, b=0x88 -> c=0x0A8, ovf=1 (product 0x2A8). a=0xFF, b=0xFF ADD -> c=0x1FE, ovf=1.
- rst asserted 3 cycles into a MUL -> no out_valid, no write to target entry, in_ready=1 next cycle, all entries 0.
- Write addr 7 while rd_addr=7 at the same edge -> d_out shows old value, new value one edge later.
